// File: rtl/io_pkg.sv
// Shared widths, defaults and types for the switch/button input conditioner.
// The debounce counter width is derived here so no instance can override it.
package io_pkg;

  localparam int IO_SW_WIDTH        = 32;
  localparam int IO_SYNC_STAGES_DEF = 2;
  localparam int IO_DEBOUNCE_DEF    = 16;

  typedef logic [IO_SW_WIDTH-1:0] io_sw_t;

  // Counter must hold 0..DEBOUNCE_CYCLES-1; a bypassed filter still gets a 1-bit width.
  function automatic int io_cnt_width(input int debounce_cycles);
    return (debounce_cycles > 0) ? $clog2(debounce_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/io_debounce_cell.sv
// One input channel: synchroniser chain, saturating debounce filter,
// registered rise/fall pulses and a sticky write-1-to-clear change flag.
module io_debounce_cell
  import io_pkg::*;
#(
  parameter int SYNC_STAGES     = IO_SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_in,
  input  logic clr,
  output logic sw,
  output logic rise,
  output logic fall,
  output logic chg,
  output logic chg_next
);

  localparam int CNT_W = io_cnt_width(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   sw_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], sw_in};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign sw_next = sync;
  end else begin : g_debounce
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Count consecutive cycles of disagreement; any agreement restarts the count.
    always_ff @(posedge clk) begin
      if (reset)                         cnt <= '0;
      else if (sync == sw || cnt == LAST) cnt <= '0;
      else                               cnt <= cnt + CNT_W'(1);
    end

    assign sw_next = (sync != sw && cnt == LAST) ? sync : sw;
  end

  // A new transition takes priority over a same-cycle clear.
  assign chg_next = (chg & ~clr) | (sw_next ^ sw);

  always_ff @(posedge clk) begin
    if (reset) begin
      sw   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
      chg  <= 1'b0;
    end else begin
      sw   <= sw_next;
      rise <= sw_next & ~sw;
      fall <= ~sw_next & sw;
      chg  <= chg_next;
    end
  end

endmodule

// File: rtl/io_input_conditioner.sv
// Conditions raw board switch/button inputs for the memory-mapped I/O block:
// one debounce cell per channel plus a registered, maskable interrupt.
module io_input_conditioner
  import io_pkg::*;
#(
  parameter int WIDTH           = IO_SW_WIDTH,
  parameter int SYNC_STAGES     = IO_SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_sw,
  input  logic [WIDTH-1:0] i_clr,
  input  logic [WIDTH-1:0] i_irq_en,
  output logic [WIDTH-1:0] o_sw,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic [WIDTH-1:0] o_chg,
  output logic             o_irq
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("io_input_conditioner: SYNC_STAGES must be in 2..4");
  end

  logic [WIDTH-1:0] chg_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    io_debounce_cell #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk     (i_clk),
      .reset   (i_reset),
      .sw_in   (i_sw[i]),
      .clr     (i_clr[i]),
      .sw      (o_sw[i]),
      .rise    (o_rise[i]),
      .fall    (o_fall[i]),
      .chg     (o_chg[i]),
      .chg_next(chg_next[i])
    );
  end

  // Built from next-state flags so the interrupt lines up with o_chg.
  always_ff @(posedge i_clk) begin
    if (i_reset) o_irq <= 1'b0;
    else         o_irq <= |(chg_next & i_irq_en);
  end

endmodule
